// File: rtl/buttons_input_if.sv
// buttons_input_if: hit handshake between the button front end and the game FSM
interface buttons_input_if;
  logic       hit_valid;
  logic       hit_ready;
  logic [3:0] hit_pos;
  logic       multi_press;
  modport master (output hit_valid, output hit_pos, output multi_press, input hit_ready);
  modport slave (input hit_valid, input hit_pos, input multi_press, output hit_ready);
endinterface

// File: rtl/buttons_input.sv
// buttons_input: sync, debounce and encode 8 whack buttons into one handshaked hit (BTN_MULTI_DETECT_EN rejects multi-presses)
module buttons_input #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      btn,
  buttons_input_if.master hit
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, PENDING, RELEASE} state_t;
  state_t        state;
  logic [7:0]    s1, btn_s, stable, stable_d, press;
  logic [CW-1:0] cnt [8];
  logic [3:0]    enc, pos_q;
  logic          valid_q, reject;
  // two-flop synchronizer on the raw pins
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1    <= '0;
      btn_s <= '0;
    end else begin
      s1    <= btn;
      btn_s <= s1;
    end
  // per-bit debounce: a level change is accepted only after DEBOUNCE_CYCLES differing samples
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stable <= '0;
      for (int k = 0; k < 8; k++) cnt[k] <= '0;
    end else begin
      for (int k = 0; k < 8; k++)
        if (btn_s[k] == stable[k]) cnt[k] <= '0;
        else if (cnt[k] == LAST) begin
          stable[k] <= btn_s[k];
          cnt[k]    <= '0;
        end else cnt[k] <= cnt[k] + 1'b1;
    end
  // delayed copy of the debounced levels for rising-edge detection
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stable_d <= '0;
    else stable_d <= stable;
  assign press = stable & ~stable_d;
  // lowest pressed index wins: bit i encodes as i+1
  always_comb begin
    enc = '0;
    for (int k = 7; k >= 0; k--)
      if (press[k]) enc = 4'(k + 1);
  end
`ifdef BTN_MULTI_DETECT_EN
  logic mp_q;
  assign reject = |(press & (press - 8'd1));
  // one-cycle flag on the edge where a multi-press is turned away from IDLE
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mp_q <= 1'b0;
    else mp_q <= (state == IDLE) && reject;
  assign hit.multi_press = mp_q;
`else
  assign reject = 1'b0;
  assign hit.multi_press = 1'b0;
`endif
  // hit FSM: offer one hit, hold it until accepted, then lock out until all buttons are released
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      pos_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (press != '0) begin
            if (reject) state <= RELEASE;
            else begin
              pos_q   <= enc;
              valid_q <= 1'b1;
              state   <= PENDING;
            end
          end
        PENDING:
          if (hit.hit_ready) begin
            pos_q   <= '0;
            valid_q <= 1'b0;
            state   <= RELEASE;
          end
        RELEASE: if (stable == '0) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  assign hit.hit_valid = valid_q;
  assign hit.hit_pos   = pos_q;
endmodule
